nand_cmd_decoder: RTL and testbench

Command decoder at the controller side of the 32-bit command link. Receives `cmd`/`start_cmd` words from the command generator and assembles multi-word write, read and erase sequences into 24-bit page addresses. Issues one operation request at a time to the NAND flash controller core through a valid/ready handshake. Flags malformed, out-of-order or unexpected words.

---
 rtl/nand_cmd_pkg.sv | 49 ++++
 rtl/nand_cmd_decoder_if.sv | 25 ++
 rtl/cmd_strobe_detect.sv | 19 +
 rtl/nand_cmd_decoder.sv | 160 ++++++++++++++++
 tb/tb_nand_cmd_decoder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nand_cmd_pkg.sv
// Shared opcodes, word keys, op encodings and FSM states
// for the NAND command-link decoder.
package nand_cmd_pkg;

    localparam logic [7:0] OPC_WRITE = 8'hAF;
    localparam logic [7:0] OPC_READ  = 8'hAD;
    localparam logic [7:0] OPC_ERASE = 8'hAE;
    localparam logic [7:0] OPC_GO    = 8'hA0;

    localparam logic [7:0] IDX_0 = 8'h00;
    localparam logic [7:0] IDX_1 = 8'h01;
    localparam logic [7:0] IDX_2 = 8'h02;
    localparam logic [7:0] IDX_3 = 8'h03;

    function automatic logic [15:0] word_key(
        input logic [7:0] opc,
        input logic [7:0] idx
    );
        return {opc, idx};
    endfunction

    localparam logic [15:0] KEY_W_HI = word_key(OPC_WRITE, IDX_0);
    localparam logic [15:0] KEY_W_LO = word_key(OPC_WRITE, IDX_1);
    localparam logic [15:0] KEY_W_GO = word_key(OPC_GO, IDX_0);
    localparam logic [15:0] KEY_R_HI = word_key(OPC_READ, IDX_0);
    localparam logic [15:0] KEY_R_LO = word_key(OPC_READ, IDX_1);
    localparam logic [15:0] KEY_E_SH = word_key(OPC_ERASE, IDX_0);
    localparam logic [15:0] KEY_E_SL = word_key(OPC_ERASE, IDX_1);
    localparam logic [15:0] KEY_E_EH = word_key(OPC_ERASE, IDX_2);
    localparam logic [15:0] KEY_E_EL = word_key(OPC_ERASE, IDX_3);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_ERASE = 2'b10
    } op_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_HI,
        ST_W_LO,
        ST_R_HI,
        ST_E_SH,
        ST_E_SL,
        ST_E_EH,
        ST_ISSUE
    } state_t;

endpackage

// File: rtl/nand_cmd_decoder_if.sv
// Command-link and operation-request bundle of the decoder.
// master: command generator / controller core, slave: decoder.
interface nand_cmd_decoder_if;

    logic [31:0] cmd;
    logic        start_cmd;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [23:0] op_addr;
    logic [23:0] op_end_addr;
    logic        op_ready;
    logic        busy;
    logic        cmd_err;

    modport master (
        output cmd, start_cmd, op_ready,
        input  op_valid, op_type, op_addr, op_end_addr, busy, cmd_err
    );

    modport slave (
        input  cmd, start_cmd, op_ready,
        output op_valid, op_type, op_addr, op_end_addr, busy, cmd_err
    );

endinterface

// File: rtl/cmd_strobe_detect.sv
// Rising-edge detector on start_cmd; word_evt is high for
// exactly one cycle per command word.
module cmd_strobe_detect (
    input  logic clk,
    input  logic rst,
    input  logic start_cmd,
    output logic word_evt
);

    logic start_cmd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) start_cmd_d <= 1'b0;
        else     start_cmd_d <= start_cmd;
    end

    assign word_evt = start_cmd & ~start_cmd_d;

endmodule

// File: rtl/nand_cmd_decoder.sv
// Multi-word command sequence decoder with one-deep op request.
// NAND_CMD_TIMEOUT_EN adds an inter-word timeout of TIMEOUT_CYCLES.
module nand_cmd_decoder
    import nand_cmd_pkg::*;
`ifdef NAND_CMD_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
    input logic               clk,
    input logic               rst,
    nand_cmd_decoder_if.slave bus
);

    logic        word_evt;
    state_t      state;
    logic [15:0] key;
    logic [15:0] payload;
    logic [7:0]  lo;
    logic [15:0] hi_q;
    logic [15:0] end_hi_q;
    logic [23:0] start_q;
    logic [23:0] end_addr;
    logic        tmo_hit;
    logic        op_valid_q;
    op_type_e    op_type_q;
    logic [23:0] op_addr_q;
    logic [23:0] op_end_q;
    logic        err_q;
    logic        unused_payload_lo;

    cmd_strobe_detect u_strobe (
        .clk       (clk),
        .rst       (rst),
        .start_cmd (bus.start_cmd),
        .word_evt  (word_evt)
    );

    assign key      = bus.cmd[31:16];
    assign payload  = bus.cmd[15:0];
    assign lo       = bus.cmd[15:8];
    assign end_addr = {end_hi_q, lo};

    assign unused_payload_lo = ^bus.cmd[7:0];

`ifdef NAND_CMD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        waiting;

    assign waiting = (state != ST_IDLE) && (state != ST_ISSUE);
    assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    tmo_cnt <= '0;
        else if (word_evt || !waiting) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + 16'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hi_q       <= '0;
            end_hi_q   <= '0;
            start_q    <= '0;
            op_valid_q <= 1'b0;
            op_type_q  <= OP_WRITE;
            op_addr_q  <= '0;
            op_end_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == ST_ISSUE) begin
                // request stays frozen; stray words are only flagged
                if (word_evt) err_q <= 1'b1;
                if (bus.op_ready) begin
                    op_valid_q <= 1'b0;
                    state      <= ST_IDLE;
                end
            end else if (word_evt) begin
                state <= ST_IDLE;
                err_q <= 1'b1;
                unique case (1'b1)
                    state == ST_IDLE && key == KEY_W_HI: begin
                        state <= ST_W_HI;
                        hi_q  <= payload;
                        err_q <= 1'b0;
                    end
                    state == ST_IDLE && key == KEY_R_HI: begin
                        state <= ST_R_HI;
                        hi_q  <= payload;
                        err_q <= 1'b0;
                    end
                    state == ST_IDLE && key == KEY_E_SH: begin
                        state <= ST_E_SH;
                        hi_q  <= payload;
                        err_q <= 1'b0;
                    end
                    state == ST_W_HI && key == KEY_W_LO: begin
                        state   <= ST_W_LO;
                        start_q <= {hi_q, lo};
                        err_q   <= 1'b0;
                    end
                    state == ST_W_LO && key == KEY_W_GO: begin
                        state      <= ST_ISSUE;
                        op_valid_q <= 1'b1;
                        op_type_q  <= OP_WRITE;
                        op_addr_q  <= start_q;
                        op_end_q   <= '0;
                        err_q      <= 1'b0;
                    end
                    state == ST_R_HI && key == KEY_R_LO: begin
                        state      <= ST_ISSUE;
                        op_valid_q <= 1'b1;
                        op_type_q  <= OP_READ;
                        op_addr_q  <= {hi_q, lo};
                        op_end_q   <= '0;
                        err_q      <= 1'b0;
                    end
                    state == ST_E_SH && key == KEY_E_SL: begin
                        state   <= ST_E_SL;
                        start_q <= {hi_q, lo};
                        err_q   <= 1'b0;
                    end
                    state == ST_E_SL && key == KEY_E_EH: begin
                        state    <= ST_E_EH;
                        end_hi_q <= payload;
                        err_q    <= 1'b0;
                    end
                    state == ST_E_EH && key == KEY_E_EL
                        && end_addr >= start_q: begin
                        state      <= ST_ISSUE;
                        op_valid_q <= 1'b1;
                        op_type_q  <= OP_ERASE;
                        op_addr_q  <= start_q;
                        op_end_q   <= end_addr;
                        err_q      <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (tmo_hit) begin
                state <= ST_IDLE;
                err_q <= 1'b1;
            end
        end
    end

    assign bus.op_valid    = op_valid_q;
    assign bus.op_type     = op_type_q;
    assign bus.op_addr     = op_addr_q;
    assign bus.op_end_addr = op_end_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_nand_cmd_decoder.sv
// Bench for nand_cmd_decoder: directed sequences plus random
// word streams against a sequence-grammar reference model.
module tb_nand_cmd_decoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nand_cmd_decoder_if bus ();

`ifdef NAND_CMD_TIMEOUT_EN
    nand_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    nand_cmd_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // model: kind 0 none, 1 write, 2 read, 3 erase
    int          m_kind  = 0;
    int          m_pos   = 0;
    logic [31:0] m_w [4];
    bit          m_issue = 1'b0;
    logic [1:0]  m_type  = 2'b00;
    logic [23:0] m_addr  = '0;
    logic [23:0] m_end   = '0;

    function automatic logic [15:0] key_of(input int kind, input int pos);
        logic [15:0] t [12];
        t = '{16'hAF00, 16'hAF01, 16'hA000, 16'h0000,
              16'hAD00, 16'hAD01, 16'h0000, 16'h0000,
              16'hAE00, 16'hAE01, 16'hAE02, 16'hAE03};
        return t[(kind - 1) * 4 + pos];
    endfunction

    function automatic int len_of(input int kind);
        return (kind == 1) ? 3 : (kind == 2) ? 2 : 4;
    endfunction

    task automatic model_word(input logic [31:0] w, output bit err);
        int k;
        err = 1'b0;
        if (m_issue) begin
            err = 1'b1;
            return;
        end
        if (m_kind == 0) begin
            k = (w[31:16] == 16'hAF00) ? 1 :
                (w[31:16] == 16'hAD00) ? 2 :
                (w[31:16] == 16'hAE00) ? 3 : 0;
            if (k == 0) begin
                err = 1'b1;
                return;
            end
            m_kind = k;
            m_pos  = 0;
        end else if (w[31:16] != key_of(m_kind, m_pos)) begin
            err    = 1'b1;
            m_kind = 0;
            return;
        end
        m_w[m_pos] = w;
        m_pos++;
        if (m_pos == len_of(m_kind)) begin
            m_type = 2'(m_kind - 1);
            m_addr = {m_w[0][15:0], m_w[1][15:8]};
            m_end  = (m_kind == 3) ? {m_w[2][15:0], m_w[3][15:8]} : 24'h0;
            m_kind = 0;
            if (m_type == 2'b10 && m_end < m_addr) err = 1'b1;
            else m_issue = 1'b1;
        end
    endtask

    task automatic check_op(input string tag);
        check({tag, "_type"}, 32'(bus.op_type), 32'(m_type));
        check({tag, "_addr"}, 32'(bus.op_addr), 32'(m_addr));
        check({tag, "_end"}, 32'(bus.op_end_addr), 32'(m_end));
    endtask

    task automatic send_word(input logic [31:0] w, input int hold,
                             input int gap);
        bit e;
        model_word(w, e);
        @(negedge clk);
        bus.cmd       = w;
        bus.start_cmd = 1'b1;
        @(negedge clk);
        check("cmd_err", 32'(bus.cmd_err), 32'(e));
        check("op_valid", 32'(bus.op_valid), 32'(m_issue));
        check("busy", 32'(bus.busy), 32'(m_issue || m_kind != 0));
        if (m_issue) check_op("op");
        repeat (hold - 1) begin
            @(negedge clk);
            check("err_held", 32'(bus.cmd_err), 32'd0);
        end
        bus.start_cmd = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic finish_issue(input bit pre, input int n_wait,
                                input bit poke);
        if (!pre) begin
            repeat (n_wait) begin
                @(negedge clk);
                check("valid_wait", 32'(bus.op_valid), 32'd1);
            end
            if (poke) send_word(32'hAF000000, 1, 1);
            bus.op_ready = 1'b1;
        end
        @(negedge clk);
        check("valid_drop", 32'(bus.op_valid), 32'd0);
        check("busy_drop", 32'(bus.busy), 32'd0);
        m_issue      = 1'b0;
        bus.op_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.op_valid), 32'd0);
        check({tag, "_type"}, 32'(bus.op_type), 32'd0);
        check({tag, "_addr"}, 32'(bus.op_addr), 32'd0);
        check({tag, "_end"}, 32'(bus.op_end_addr), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_err"}, 32'(bus.cmd_err), 32'd0);
    endtask

    task automatic reset_now(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst     = 1'b0;
        m_kind  = 0;
        m_issue = 1'b0;
    endtask

    function automatic logic [31:0] gen_word();
        logic [15:0] key;
        logic [15:0] pl;
        logic [7:0]  ops [5];
        pl  = 16'($urandom);
        ops = '{8'hAF, 8'hAD, 8'hAE, 8'hA0, 8'($urandom)};
        if ($urandom_range(0, 9) < 8) begin
            if (m_kind == 0) key = key_of(int'($urandom_range(1, 3)), 0);
            else key = key_of(m_kind, m_pos);
            if (m_kind == 3 && m_pos >= 2 && $urandom_range(0, 1) == 1)
                pl = m_w[m_pos - 2][15:0];
        end else begin
            key = {ops[$urandom_range(0, 4)], 8'($urandom_range(0, 3))};
        end
        return {key, pl};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit pre;
        rst           = 1'b1;
        bus.cmd       = '0;
        bus.start_cmd = 1'b0;
        bus.op_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // write
        send_word(32'hAF000108, 4, 3);
        send_word(32'hAF010400, 4, 3);
        send_word(32'hA0000000, 4, 3);
        finish_issue(1'b0, 2, 1'b0);

        // read, ready low 10 cycles
        send_word(32'hAD000108, 4, 3);
        send_word(32'hAD010400, 4, 3);
        finish_issue(1'b0, 10, 1'b0);

        // erase equal, then end below start
        send_word(32'hAE000108, 4, 3);
        send_word(32'hAE010400, 4, 3);
        send_word(32'hAE020108, 4, 3);
        send_word(32'hAE030400, 4, 3);
        finish_issue(1'b0, 1, 1'b0);
        send_word(32'hAE000108, 4, 3);
        send_word(32'hAE010400, 4, 3);
        send_word(32'hAE020107, 4, 3);
        send_word(32'hAE030400, 4, 3);

        // out of order, then recovery
        send_word(32'hAF000108, 4, 3);
        send_word(32'hAD010400, 4, 3);
        send_word(32'hAF000108, 4, 3);
        send_word(32'hAF010400, 4, 3);
        send_word(32'hA0000000, 4, 3);

        // word during issue, then reset mid-issue and mid-sequence
        send_word(32'hAF000000, 2, 2);
        reset_now("rst_issue");
        send_word(32'hAD001234, 2, 2);
        reset_now("rst_seq");

        // ready high before valid: no shortcut
        send_word(32'hAD00ABCD, 2, 2);
        bus.op_ready = 1'b1;
        send_word(32'hAD01EF00, 1, 0);
        finish_issue(1'b1, 0, 1'b0);

`ifdef NAND_CMD_TIMEOUT_EN
        send_word(32'hAF000108, 1, 0);
        repeat (15) begin
            @(negedge clk);
            check("tmo_early", 32'(bus.cmd_err), 32'd0);
        end
        @(negedge clk);
        check("tmo_err", 32'(bus.cmd_err), 32'd1);
        check("tmo_busy", 32'(bus.busy), 32'd0);
        m_kind = 0;
`endif

        for (int i = 0; i < 160; i++) begin
            pre = ($urandom_range(0, 3) == 0);
            if (pre) begin
                bus.op_ready = 1'b1;
                send_word(gen_word(), 1, 0);
            end else begin
                send_word(gen_word(), int'($urandom_range(1, 4)),
                          int'($urandom_range(0, 4)));
            end
            if (m_issue)
                finish_issue(pre, int'($urandom_range(0, 5)),
                             $urandom_range(0, 3) == 0);
            bus.op_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
